// File: rtl/token_msg_gate.sv
// token_msg_gate: message-framing gate for a forward-token stream.
// Tokens inside an acquire..release message pass through with one cycle of
// latency; tokens outside a message are dropped and flagged as orphans, and an
// acquire inside an open message is forwarded and flagged as nesting.
// Optional feature macro: TOKEN_MSG_GATE_LEN_CNT_EN adds an 8-bit saturating
// payload-word counter and the O_msg_len output.

package token_msg_gate_pkg;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic              v;
        logic              a;
        logic              r;
        logic [DATA_W-1:0] data;
    } FTk_t;
endpackage

module token_msg_gate
    import token_msg_gate_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  FTk_t       I_FTk,
    output logic       O_Nack,
    output FTk_t       O_FTk,
    input  logic       I_Nack,
    output logic       O_busy,
    output logic       O_err_orphan,
    output logic       O_err_nest
`ifdef TOKEN_MSG_GATE_LEN_CNT_EN
    ,
    output logic [7:0] O_msg_len
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        MSG  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic hold;
    logic consumed;
    logic is_acq;
    logic is_rls;
    logic fwd;
    logic orphan_d;
    logic nest_d;

    // Handshake: a token on I_FTk with v=1 is consumed on a rising edge unless
    // O_Nack is 1 in that cycle. O_Nack is raised only when downstream stalls
    // (I_Nack=1) while O_FTk holds a valid token; an empty output register
    // never stalls, so I_Nack alone does not block upstream.
    assign hold     = I_Nack & O_FTk.v;
    assign O_Nack   = hold;
    assign consumed = I_FTk.v & ~hold;

    assign is_acq = I_FTk.v &  I_FTk.a & ~I_FTk.r;
    assign is_rls = I_FTk.v &  I_FTk.a &  I_FTk.r;

    // O_busy is the state register itself, so it doubles as the FSM debug view.
    assign O_busy = (state_q == MSG);

    // Next-state, forward decision and error detection for the consumed token.
    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        orphan_d = 1'b0;
        nest_d   = 1'b0;
        if (consumed) begin
            case (state_q)
                IDLE: begin
                    if (is_acq) begin
                        fwd     = 1'b1;
                        state_d = MSG;
                    end else begin
                        orphan_d = 1'b1;
                    end
                end
                MSG: begin
                    fwd = 1'b1;
                    if (is_acq) begin
                        nest_d = 1'b1;
                    end else if (is_rls) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, output token register and one-cycle error pulses.
    // During a hold the token stays put and no new error can be raised.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            O_FTk        <= '0;
            O_err_orphan <= 1'b0;
            O_err_nest   <= 1'b0;
        end else if (!hold) begin
            state_q      <= state_d;
            O_FTk        <= fwd ? I_FTk : '0;
            O_err_orphan <= orphan_d;
            O_err_nest   <= nest_d;
        end else begin
            O_err_orphan <= 1'b0;
            O_err_nest   <= 1'b0;
        end
    end

`ifdef TOKEN_MSG_GATE_LEN_CNT_EN
    logic       is_data;
    logic [7:0] len_cnt;

    assign is_data = I_FTk.v & ~I_FTk.a & ~I_FTk.r;

    // Payload word counter: cleared by an opening acquire (not a nested one),
    // saturates at 255, latched into O_msg_len when the release is consumed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_cnt   <= 8'd0;
            O_msg_len <= 8'd0;
        end else if (consumed) begin
            if (state_q == IDLE && is_acq) begin
                len_cnt <= 8'd0;
            end else if (state_q == MSG && is_data && len_cnt != 8'hFF) begin
                len_cnt <= len_cnt + 8'd1;
            end
            if (state_q == MSG && is_rls) begin
                O_msg_len <= len_cnt;
            end
        end
    end
`endif

endmodule

// File: doc/token_msg_gate.md
TOKEN_MSG_GATE -- requirements
Module: token_msg_gate

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port I_FTk, input, FTk_t, upstream forward token (fields v, a, r, data).
REQ-004 SHALL have port O_Nack, output, 1, back-pressure to upstream; 1 means I_FTk not consumed this cycle.
REQ-005 SHALL have port O_FTk, output, FTk_t, registered forward token to downstream.
REQ-006 SHALL have port I_Nack, input, 1, back-pressure from downstream.
REQ-007 SHALL have port O_busy, output, 1, 1 while a message is open (state MSG).
REQ-008 SHALL have port O_err_orphan, output, 1, one-cycle pulse on a dropped out-of-message token.
REQ-009 SHALL have port O_err_nest, output, 1, one-cycle pulse on acquire received inside an open message.
REQ-010 SHALL have port O_msg_len, output, 8, payload word count of the last closed message (present only per REQ-027).

Function
REQ-011 SHALL classify I_FTk: acq = v&a&~r; rls = v&a&r; frag_rls = v&~a&r; data = v&~a&~r.
REQ-012 SHALL implement a two-state FSM: IDLE, MSG.
REQ-013 IDLE->MSG on consumed acq; MSG->IDLE on consumed rls; no other transitions.
REQ-014 SHALL register accepted tokens into O_FTk with latency exactly 1 cycle; O_FTk.v=0 when nothing was accepted.
REQ-015 hold: I_Nack=1 and O_FTk.v=1 -> O_FTk keeps its value, O_Nack=1 (combinational), I_FTk not consumed, FSM/counter/errors unchanged.
REQ-016 I_Nack=1 with O_FTk.v=0 -> no hold; input accepted normally, O_Nack=0.
REQ-017 IDLE: acq forwarded; data, rls, frag_rls dropped (not forwarded), O_err_orphan pulses next cycle.
REQ-018 MSG: data and frag_rls forwarded, state unchanged; rls forwarded, closes message.
REQ-019 MSG: acq forwarded, state stays MSG, O_err_nest pulses next cycle, counter not cleared.
REQ-020 I_FTk.v=0 -> no state change, O_FTk.v=0 next cycle (unless held).
REQ-021 O_busy SHALL equal (state==MSG), registered.
REQ-022 error pulses SHALL be registered, width exactly one cycle per offending token; back-to-back offenders give back-to-back pulses.

Reset
REQ-023 reset low SHALL force state IDLE, O_FTk all zero, O_busy=0, O_err_orphan=0, O_err_nest=0, counter=0, O_msg_len=0, asynchronously.
REQ-024 reset asserted mid-message SHALL discard the open message and held token; after release the first accepted non-acq token is an orphan.
REQ-025 O_Nack SHALL be 0 during reset.

Configuration
REQ-026 macro TOKEN_MSG_GATE_LEN_CNT_EN SHALL select length counting.
REQ-027 defined: 8-bit counter cleared to 0 on consumed acq in IDLE, +1 per consumed data word in MSG, saturates at 255 (no wrap); on consumed rls, O_msg_len <= counter (same cycle rls appears on O_FTk).
REQ-028 undefined: no counter; O_msg_len port absent; all other behaviour identical.

Verification
REQ-029 acq, 3 data, rls, no nack -> O_FTk same 5 tokens delayed 1 cycle; O_busy 1 for 4 cycles; O_msg_len=3 (macro on).
REQ-030 IDLE, data then rls -> O_FTk.v stays 0; O_err_orphan pulses 2 consecutive cycles; O_busy=0.
REQ-031 acq, data; I_Nack=1 for 3 cycles while data on O_FTk -> O_FTk stable 3 cycles, O_Nack=1 for 3 cycles, no loss/duplication after release.
REQ-032 acq, acq, data, rls -> all 4 forwarded; O_err_nest one pulse; O_msg_len=1.
REQ-033 acq then 300 data then rls (macro on) -> O_msg_len=255.
REQ-034 acq, 2 data, reset low 1 cycle, then data -> outputs zero during reset; post-reset data dropped, O_err_orphan=1.
